// File: rtl/text_display_engine.sv
// Character-cell text video engine: raster timing, text/font fetch pipeline, blinking cursor.
// Define TEXT_ATTR_EN to colour each cell from a fixed CGA palette indexed by its attribute byte.
module text_display_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int BLINK_FRAMES = 32,
  localparam int COLS = H_ACTIVE / CHAR_W,
  localparam int ROWS = V_ACTIVE / CHAR_H,
  localparam int AW   = $clog2(COLS * ROWS),
  localparam int XW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int LCH  = $clog2(CHAR_H)
) (
  input  logic              pixelClk,
  input  logic              n_reset,
  input  logic [XW-1:0]     cursor_x,
  input  logic [YW-1:0]     cursor_y,
  input  logic              cursor_en,
  output logic [AW-1:0]     cell_addr,
  output logic              cell_rd,
  input  logic [15:0]       cell_data,
  output logic [8+LCH-1:0]  font_addr,
  input  logic [CHAR_W-1:0] font_data,
  output logic              hSync,
  output logic              vSync,
  output logic              hblank,
  output logic              vblank,
  output logic [3:0]        videoR,
  output logic [3:0]        videoG,
  output logic [3:0]        videoB,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int LCW = $clog2(CHAR_W);
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [4:0] SYNC_IDLE = 5'b11110;  // {hSync, vSync, hblank, vblank, frame_start}

  logic              run_reg;
  logic [HW-1:0]     h_cnt_reg;
  logic [VW-1:0]     v_cnt_reg;
  logic [AW-1:0]     row_base_reg;
  logic [XW-1:0]     cur_x_reg;
  logic [YW-1:0]     cur_y_reg;
  logic [BW-1:0]     blink_cnt_reg;
  logic              blink_on_reg;
  logic              line_end, frame_end, row_step, active0, hit0;
  logic [LCW-1:0]    xoff0;
  logic [LCH-1:0]    line0;
  logic [HW-LCW-1:0] col0;
  logic [VW-LCH-1:0] row0;
  logic [4:0]        sync0;
  logic [4:0]        sync_pipe_reg [1:3];
  logic              active1_reg, hit1_reg, active2_reg, hit2_reg;
  logic [LCW-1:0]    xoff1_reg, xoff2_reg;
  logic [LCH-1:0]    line1_reg;
  logic [11:0]       colour_reg, fg, bg;
  logic              pix2;

  assign line_end  = run_reg && (h_cnt_reg == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v_cnt_reg == VW'(V_TOTAL - 1));
  assign xoff0 = h_cnt_reg[LCW-1:0];
  assign line0 = v_cnt_reg[LCH-1:0];
  assign col0  = h_cnt_reg[HW-1:LCW];
  assign row0  = v_cnt_reg[VW-1:LCH];
  // Row base only steps inside the active area so it never exceeds COLS*ROWS-1.
  assign row_step = (v_cnt_reg < VW'(V_ACTIVE - 1)) && (line0 == LCH'(CHAR_H - 1));

  assign active0 = run_reg && (h_cnt_reg < HW'(H_ACTIVE)) && (v_cnt_reg < VW'(V_ACTIVE));
  // Exact equality means an out-of-range cursor can never match a visible cell.
  assign hit0 = active0 && cursor_en && blink_on_reg &&
                (32'(col0) == 32'(cur_x_reg)) && (32'(row0) == 32'(cur_y_reg));

  assign sync0 = {
    !(run_reg && h_cnt_reg >= HW'(H_ACTIVE + H_FP) && h_cnt_reg < HW'(H_ACTIVE + H_FP + H_SYNC)),
    !(run_reg && v_cnt_reg >= VW'(V_ACTIVE + V_FP) && v_cnt_reg < VW'(V_ACTIVE + V_FP + V_SYNC)),
    !run_reg || (h_cnt_reg >= HW'(H_ACTIVE)),
    !run_reg || (v_cnt_reg >= VW'(V_ACTIVE)),
    run_reg && (h_cnt_reg == '0) && (v_cnt_reg == '0)
  };

  assign cell_addr = row_base_reg + AW'(col0);
  assign cell_rd   = active0;
  assign font_addr = {cell_data[7:0], line1_reg};

  // run_reg is the stage-0 valid bit: the first edge after reset presents pixel (0,0).
  always_ff @(posedge pixelClk or negedge n_reset) begin
    if (!n_reset) begin
      run_reg       <= 1'b0;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      row_base_reg  <= '0;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else begin
      run_reg <= 1'b1;
      if (run_reg) h_cnt_reg <= line_end ? '0 : h_cnt_reg + 1'b1;
      if (line_end) v_cnt_reg <= frame_end ? '0 : v_cnt_reg + 1'b1;
      if (frame_end) row_base_reg <= '0;
      else if (line_end && row_step) row_base_reg <= row_base_reg + AW'(COLS);
      if (!run_reg || frame_end) begin
        cur_x_reg <= cursor_x;
        cur_y_reg <= cursor_y;
      end
      if (frame_end) begin
        if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixelClk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 1; i <= 3; i++) sync_pipe_reg[i] <= SYNC_IDLE;
    end else begin
      for (int i = 3; i > 1; i--) sync_pipe_reg[i] <= sync_pipe_reg[i-1];
      sync_pipe_reg[1] <= sync0;
    end
  end

`ifdef TEXT_ATTR_EN
  logic [7:0] attr2_reg;

  function automatic logic [11:0] cga_palette(input logic [3:0] idx);
    case (idx)
      4'h0: cga_palette = 12'h000;  4'h1: cga_palette = 12'h00A;
      4'h2: cga_palette = 12'h0A0;  4'h3: cga_palette = 12'h0AA;
      4'h4: cga_palette = 12'hA00;  4'h5: cga_palette = 12'hA0A;
      4'h6: cga_palette = 12'hA50;  4'h7: cga_palette = 12'hAAA;
      4'h8: cga_palette = 12'h555;  4'h9: cga_palette = 12'h55F;
      4'hA: cga_palette = 12'h5F5;  4'hB: cga_palette = 12'h5FF;
      4'hC: cga_palette = 12'hF55;  4'hD: cga_palette = 12'hF5F;
      4'hE: cga_palette = 12'hFF5;  default: cga_palette = 12'hFFF;
    endcase
  endfunction

  always_ff @(posedge pixelClk or negedge n_reset) begin
    if (!n_reset) attr2_reg <= '0;
    else          attr2_reg <= cell_data[15:8];
  end

  assign fg = cga_palette(attr2_reg[3:0]);
  assign bg = cga_palette(attr2_reg[7:4]);
`else
  logic attr_unused;
  assign attr_unused = ^cell_data[15:8];
  assign fg = 12'hFFF;
  assign bg = 12'h000;
`endif

  // Glyph rows are MSB-leftmost, so pixel offset x selects bit ~x.
  assign pix2 = font_data[~xoff2_reg] ^ hit2_reg;

  always_ff @(posedge pixelClk or negedge n_reset) begin
    if (!n_reset) begin
      active1_reg <= 1'b0;
      hit1_reg    <= 1'b0;
      xoff1_reg   <= '0;
      line1_reg   <= '0;
      active2_reg <= 1'b0;
      hit2_reg    <= 1'b0;
      xoff2_reg   <= '0;
      colour_reg  <= '0;
    end else begin
      active1_reg <= active0;
      hit1_reg    <= hit0;
      xoff1_reg   <= xoff0;
      line1_reg   <= line0;
      active2_reg <= active1_reg;
      hit2_reg    <= hit1_reg;
      xoff2_reg   <= xoff1_reg;
      colour_reg  <= active2_reg ? (pix2 ? fg : bg) : 12'h000;
    end
  end

  assign {hSync, vSync, hblank, vblank, frame_start} = sync_pipe_reg[3];
  assign {videoR, videoG, videoB} = colour_reg;
endmodule

// File: tb/tb_text_display_engine.sv
// Bench for text_display_engine on a reduced 80x54 raster (8x3 cells) with a pixel-index reference model.
module tb_text_display_engine;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 2;
  localparam int CW = 8, CH = 16, BF = 2;
  localparam int HT = 80, VT = 54, FT = HT * VT, COLS = 8;
`ifdef TEXT_ATTR_EN
  localparam logic [11:0] FG_LIT = 12'hAAA;  // palette[7] for attribute 8'h07
  localparam logic [11:0] BG28   = 12'h00A;  // palette[1] for attribute 8'h1F
`else
  localparam logic [11:0] FG_LIT = 12'hFFF;
  localparam logic [11:0] BG28   = 12'h000;
`endif

  logic        pixelClk = 1'b0;
  logic        n_reset = 1'b0;
  logic [2:0]  cursor_x;
  logic [1:0]  cursor_y;
  logic        cursor_en;
  logic [4:0]  cell_addr;
  logic        cell_rd;
  logic [15:0] cell_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        hSync, vSync, hblank, vblank, frame_start;
  logic [3:0]  videoR, videoG, videoB;

  logic [15:0] text_ram [0:31];
  logic [7:0]  font_rom [0:4095];
  int n = 0;
  int samp_x [0:15];
  int samp_y [0:15];
  int run_id = 0;
  int checks = 0;
  int failures = 0;

  text_display_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CHAR_W(CW), .CHAR_H(CH), .BLINK_FRAMES(BF)
  ) dut (
    .pixelClk(pixelClk), .n_reset(n_reset),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .cell_addr(cell_addr), .cell_rd(cell_rd), .cell_data(cell_data),
    .font_addr(font_addr), .font_data(font_data),
    .hSync(hSync), .vSync(vSync), .hblank(hblank), .vblank(vblank),
    .videoR(videoR), .videoG(videoG), .videoB(videoB),
    .frame_start(frame_start)
  );

  always #5 pixelClk = ~pixelClk;

  // Synchronous external memories: data valid one cycle after address.
  always @(posedge pixelClk) begin
    if (cell_rd) cell_data <= text_ram[cell_addr];
    font_data <= font_rom[font_addr];
  end

  // n = rising edges since reset release; pixel n-1 is in the counters, pixel n-4 is on the pins.
  always @(posedge pixelClk or negedge n_reset) begin
    if (!n_reset) n <= 0;
    else begin
      if (n % FT == 0) begin
        samp_x[(n / FT) % 16] <= int'(cursor_x);
        samp_y[(n / FT) % 16] <= int'(cursor_y);
      end
      n <= n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, run %0d)", name, act, exp, n, run_id);
    end
  endtask

  function automatic logic [11:0] palette(input int i);
    logic [11:0] tbl [0:15];
    tbl = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    return tbl[i];
  endfunction

  function automatic bit is_active(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction

  function automatic int addr_of(input int p);
    return ((((p / HT) % VT) / CH) * COLS) + ((p % HT) / CW);
  endfunction

  function automatic logic [4:0] exp_sync(input int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    return {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
            h >= HA, v >= VA, (h == 0 && v == 0)};
  endfunction

  function automatic logic [11:0] exp_colour(input int q);
    int h, v, f, col, row;
    logic [15:0] w;
    logic [7:0] g;
    logic b;
    logic [11:0] fg, bg;
    h = q % HT;
    v = (q / HT) % VT;
    f = q / FT;
    if (h >= HA || v >= VA) return 12'h000;
    col = h / CW;
    row = v / CH;
    w = text_ram[row * COLS + col];
    g = font_rom[int'(w[7:0]) * CH + (v % CH)];
    b = g[CW - 1 - (h % CW)];
    if (cursor_en && ((f / BF) % 2 == 0) && samp_x[f % 16] == col && samp_y[f % 16] == row) b = ~b;
`ifdef TEXT_ATTR_EN
    fg = palette(int'(w[11:8]));
    bg = palette(int'(w[15:12]));
`else
    fg = 12'hFFF;
    bg = 12'h000;
`endif
    return b ? fg : bg;
  endfunction

  // Per-cycle comparison against the model, plus literal spot checks.
  initial begin
    int nn, q, p;
    int last_hfall, last_vfall, last_fs;
    logic prev_hs, prev_vs;
    logic [11:0] colour;
    logic [11:0] cur5_exp [0:5];
    cur5_exp = '{FG_LIT, FG_LIT, 12'h000, 12'h000, FG_LIT, 12'h000};
    last_hfall = -1; last_vfall = -1; last_fs = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    forever begin
      @(negedge pixelClk);
      nn = n;
      colour = {videoR, videoG, videoB};
      if (!n_reset || nn < 4) begin
        chk("sync_idle", {hSync, vSync, hblank, vblank, frame_start}, 5'b11110);
        chk("colour_idle", colour, 12'h000);
      end else begin
        q = nn - 4;
        chk("sync", {hSync, vSync, hblank, vblank, frame_start}, exp_sync(q));
        chk("colour", colour, exp_colour(q));
      end
      if (n_reset && nn >= 1) begin
        p = nn - 1;
        chk("cell_rd", cell_rd, is_active(p));
        if (is_active(p)) chk("cell_addr", cell_addr, addr_of(p));
      end else begin
        chk("cell_rd_idle", cell_rd, 0);
      end
      if (n_reset && nn >= 2 && is_active(nn - 2)) begin
        p = nn - 2;
        chk("font_addr", font_addr, {text_ram[addr_of(p)][7:0], 4'(((p / HT) % VT) % CH)});
      end
      if (!n_reset) begin
        last_hfall = -1; last_vfall = -1; last_fs = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
      end else begin
        // Literal timing figures for the 80x54 raster: hsync 80/8, vsync 4320/160 cycles.
        if (prev_hs && !hSync) begin
          if (last_hfall >= 0) chk("hsync_period", nn - last_hfall, 80);
          last_hfall = nn;
        end
        if (!prev_hs && hSync && last_hfall >= 0) chk("hsync_low", nn - last_hfall, 8);
        if (prev_vs && !vSync) begin
          if (last_vfall >= 0) chk("vsync_period", nn - last_vfall, 4320);
          last_vfall = nn;
        end
        if (!prev_vs && vSync && last_vfall >= 0) chk("vsync_low", nn - last_vfall, 160);
        if (frame_start === 1'b1) begin
          if (last_fs >= 0) chk("frame_period", nn - last_fs, 4320);
          last_fs = nn;
        end
        prev_hs = hSync;
        prev_vs = vSync;
        if (nn == 3) chk("no_early_frame_start", frame_start, 0);
        if (nn == 4) chk("first_frame_start", frame_start, 1);
        // Pixel (17,35): cell row 2, col 2 -> addr 18, char 8'h52, glyph line 3.
        if (run_id == 0 && nn - 1 == 2817) chk("cell_addr_17_35", cell_addr, 18);
        if (run_id == 0 && nn - 2 == 2817) chk("font_addr_17_35", font_addr, 12'h523);
        if (run_id == 0 && nn - 4 == 8) chk("attr_first_px", colour, 12'hFFF);
        if (run_id == 0 && nn - 4 >= 9 && nn - 4 <= 15) chk("attr_rest_px", colour, BG28);
        if (nn >= 4) begin
          q = nn - 4;
          if (run_id == 0 && q % FT == 2600 && q / FT <= 5) chk("cursor_col5", colour, cur5_exp[q / FT]);
          if (run_id == 0 && q == 4 * FT + 2584) chk("cursor_col3_f4", colour, 12'h000);
          if (run_id == 0 && q == 5 * FT + 2584) chk("cursor_col3_f5", colour, FG_LIT);
          if (run_id == 1 && (q == 2600 || q == 2584)) chk("cursor_out_of_range", colour, 12'h000);
        end
      end
    end
  end

  task automatic wait_pix(input int target);
    int i;
    i = 0;
    while (!(n_reset && n >= 1 && n - 1 >= target) && i < 100000) begin
      @(negedge pixelClk);
      i++;
    end
    if (i >= 100000) begin
      checks++;
      failures++;
      $display("FAIL wait_pix: got timeout expected pixel %0d", target);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) text_ram[i] = {8'h07, 8'(8'h40 + i)};
    text_ram[1] = 16'h1F41;
    for (int i = 0; i < 4096; i++) font_rom[i] = 8'((i * 37) ^ (i >> 3));
    font_rom[12'h410] = 8'h80;
    font_rom[12'h550] = 8'h00;
    font_rom[12'h530] = 8'h00;
    cursor_x = 3'd5;
    cursor_y = 2'd2;
    cursor_en = 1'b1;
    n_reset = 1'b0;
    repeat (4) @(negedge pixelClk);
    #2 n_reset = 1'b1;
    wait_pix(4 * FT + 10 * HT);
    #2 cursor_x = 3'd3;
    wait_pix(6 * FT + 20 * HT + 30);
    #2 n_reset = 1'b0;
    repeat (5) @(negedge pixelClk);
    #2;
    cursor_y = 2'd3;
    run_id = 1;
    n_reset = 1'b1;
    wait_pix(FT + 60);
    repeat (3) @(negedge pixelClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
